mtimer_clint: RTL and testbench
===============================

// Module: mtimer_clint
// PURPOSE
//  Machine timer peripheral: owns the free-running 64-bit mtime counter and the mtimecmp compare register.
//  Drives real_mtime into the CSR unit's time/timeh CSRs and raises the machine timer interrupt (mtip).
//  Software reaches it through a simple valid/ready memory-mapped slave port on the data bus.
// PARAMETERS
//  PRESCALE   1    clk cycles per mtime increment; legal range 1..65535.
//  BASE_ADDR  32'h0200_0000  bus base address; the block decodes addr[4:2] and ignores addr[1:0].
// PORTS
//  clk        in   1   system clock; all state changes on the rising edge.
//  rst        in   1   asynchronous, active-low reset.
//  bus_valid  in   1   access request; held high until bus_ready.
//  bus_we     in   1   1 = write, 0 = read; stable while bus_valid is high.
//  bus_addr   in   32  byte address; stable while bus_valid is high.
//  bus_wdata  in   32  write data; stable while bus_valid is high.
//  bus_ready  out  1   one-cycle access-complete pulse.
//  bus_rdata  out  32  read data; valid only while bus_ready=1, otherwise 0.
//  real_mtime out  64  current mtime value, registered output.
//  mtip       out  1   timer interrupt pending, registered output.
// BEHAVIOUR
//  Register map (offset from BASE_ADDR):
//   0x00 MTIME_LO    RW
//   0x04 MTIME_HI    RW
//   0x08 MTIMECMP_LO RW
//   0x0C MTIMECMP_HI RW
//   0x10 CTRL        RW, bit0 EN, bits 31:1 read as 0
//   Any other offset: reads return 0, writes are ignored, bus_ready is still given.
//  Reset values:
//   mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, EN=1, prescaler=0, hi_shadow=0.
//   bus_ready=0, bus_rdata=0, mtip=0, FSM=IDLE.
//  Prescaler:
//   When EN=1, the prescaler counts 0..PRESCALE-1.
//   On the cycle it equals PRESCALE-1, it wraps to 0 and mtime increments by 1.
//   mtime is a 64-bit modulo counter: FFFF_FFFF_FFFF_FFFF wraps to 0.
//   With PRESCALE=1, mtime increments every cycle.
//   When EN=0, the prescaler and mtime both hold. Writing EN=0 does not clear the prescaler.
//  Bus FSM, two states:
//   IDLE: bus_valid=1 -> accept the access and go to RESP.
//         Writes update the target register at this accepting edge.
//         Reads capture bus_rdata at this edge.
//   RESP: bus_ready=1 for exactly one cycle, then back to IDLE.
//  Latency and throughput:
//   bus_ready rises on the cycle after acceptance (fixed latency of 1).
//   The next access can be accepted on the cycle after RESP, so one access takes 2 cycles.
//   bus_valid low in RESP is a protocol violation; the response is still produced.
//  Atomic 64-bit read:
//   A read of MTIME_LO returns mtime[31:0] and loads hi_shadow <= mtime[63:32] at the same edge.
//   A read of MTIME_HI returns hi_shadow, not the live mtime[63:32].
//   Software reads LO then HI to get a tear-free value.
//  Write/increment collision:
//   A bus write to MTIME_LO or MTIME_HI at an increment edge wins.
//   The written half takes wdata; the other half keeps its pre-increment value.
//   No carry is applied on that edge. The prescaler is unaffected.
//  Interrupt:
//   mtip <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated every edge regardless of EN.
//   Latency: one cycle after mtime or mtimecmp changes.
//   Writing mtimecmp above mtime clears mtip on the next edge.
//  real_mtime == mtime register, presented directly.
//  Reset asserted mid-access:
//   All state returns to the reset values immediately, any pending bus_ready is dropped, no partial write is kept.
// TESTING
//  T1 Release reset, PRESCALE=1, idle 10 cycles
//     -> real_mtime=10, mtip=0, bus_ready=0, bus_rdata=0.
//  T2 PRESCALE=4, 16 cycles after reset
//     -> real_mtime=4.
//     Then write CTRL=0, idle 8 cycles -> real_mtime unchanged.
//     Then write CTRL=1 -> counting resumes from the same prescaler phase.
//  T3 Write MTIME_HI=0, MTIME_LO=32'hFFFF_FFFE; read LO then HI across the carry
//     -> LO=FFFF_FFFF or less, HI=0 (shadow value).
//     Fresh LO/HI pair afterwards -> HI=1.
//  T4 Write MTIMECMP_HI=0, MTIMECMP_LO=mtime+20
//     -> mtip rises exactly one cycle after mtime reaches cmp.
//     Then write MTIMECMP_LO=FFFF_FFFF -> mtip falls one cycle later.
//  T5 Write MTIME_LO=32'h100 on the edge where the prescaler wraps
//     -> mtime[31:0]=0x100 (no +1); next increment gives 0x101.
//     Read of offset 0x14 -> 0, with bus_ready.
//  T6 Assert rst in the RESP cycle of a MTIMECMP_LO write
//     -> bus_ready=0 immediately; after release, mtimecmp=all-ones and mtime=0.

Source files
------------

// File: rtl/mtimer_clint.sv
// Machine timer: free-running 64-bit mtime with prescaler, mtimecmp compare and mtip,
// reached through a two-state valid/ready slave port.
//   state   | meaning
//   ST_IDLE | waiting for bus_valid; accepts, writes and captures read data on the same edge
//   ST_RESP | bus_ready high for one cycle, then back to ST_IDLE
module mtimer_clint #(
   parameter int unsigned PRESCALE  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_valid,
   input  logic        bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ready,
   output logic [31:0] bus_rdata,
   output logic [63:0] real_mtime,
   output logic        mtip
);
   localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   state_t      state_q;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [31:0] hi_shadow_q, hi_shadow_d;
   logic [15:0] presc_q, presc_d;
   logic        en_q, en_d;
   logic        bus_ready_q;
   logic [31:0] bus_rdata_q;
   logic        mtip_q;

   logic        hit;
   logic [2:0]  reg_sel;
   logic        accept;
   logic        wr;
   logic        rd;
   logic        tick;
   logic [31:0] rdata_mux;
   logic        unused_addr;

   // Window match on the upper bits; byte lanes within a word are ignored.
   assign hit         = (bus_addr[31:5] == BASE_ADDR[31:5]);
   assign reg_sel     = bus_addr[4:2];
   assign unused_addr = ^bus_addr[1:0];

   assign accept = (state_q == ST_IDLE) && bus_valid;
   assign wr     = accept && bus_we && hit;
   assign rd     = accept && !bus_we && hit;
   assign tick   = en_q && (presc_q == PS_LAST);

   always_comb begin
      rdata_mux = 32'h0;
      if (hit) begin
         case (reg_sel)
            3'd0:    rdata_mux = mtime_q[31:0];
            3'd1:    rdata_mux = hi_shadow_q;
            3'd2:    rdata_mux = mtimecmp_q[31:0];
            3'd3:    rdata_mux = mtimecmp_q[63:32];
            3'd4:    rdata_mux = {31'h0, en_q};
            default: rdata_mux = 32'h0;
         endcase
      end
   end

   always_comb begin
      presc_d     = presc_q;
      mtime_d     = mtime_q;
      mtimecmp_d  = mtimecmp_q;
      en_d        = en_q;
      hi_shadow_d = hi_shadow_q;

      if (en_q) begin
         presc_d = (presc_q == PS_LAST) ? 16'h0 : presc_q + 16'h1;
      end
      if (tick) begin
         mtime_d = mtime_q + 64'h1;
      end

      // A bus write to either mtime half overrides the increment; no carry that edge.
      if (wr) begin
         case (reg_sel)
            3'd0:    mtime_d = {mtime_q[63:32], bus_wdata};
            3'd1:    mtime_d = {bus_wdata, mtime_q[31:0]};
            3'd2:    mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
            3'd3:    mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
            3'd4:    en_d = bus_wdata[0];
            default: en_d = en_q;
         endcase
      end

      if (rd && (reg_sel == 3'd0)) begin
         hi_shadow_d = mtime_q[63:32];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         bus_ready_q <= 1'b0;
         bus_rdata_q <= 32'h0;
         mtime_q     <= 64'h0;
         mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_q        <= 1'b1;
         presc_q     <= 16'h0;
         hi_shadow_q <= 32'h0;
         mtip_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus_valid) begin
                  state_q     <= ST_RESP;
                  bus_ready_q <= 1'b1;
                  bus_rdata_q <= bus_we ? 32'h0 : rdata_mux;
               end
            end
            ST_RESP: begin
               state_q     <= ST_IDLE;
               bus_ready_q <= 1'b0;
               bus_rdata_q <= 32'h0;
            end
            default: begin
               state_q     <= ST_IDLE;
               bus_ready_q <= 1'b0;
               bus_rdata_q <= 32'h0;
            end
         endcase
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         en_q        <= en_d;
         presc_q     <= presc_d;
         hi_shadow_q <= hi_shadow_d;
         mtip_q      <= (mtime_q >= mtimecmp_q);
      end
   end

   assign bus_ready  = bus_ready_q;
   assign bus_rdata  = bus_rdata_q;
   assign real_mtime = mtime_q;
   assign mtip       = mtip_q;

endmodule

// File: tb/tb_mtimer_clint.sv
// Bench for mtimer_clint: two instances (PRESCALE 1 and 4) share one bus and are
// compared every cycle against a cycle-level behavioural model, plus directed sequences.
`timescale 1ns/1ps
module tb_mtimer_clint;
   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        bus_valid = 1'b0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_addr = BASE;
   logic [31:0] bus_wdata = 32'h0;
   logic        rdy0, rdy1, mtip0, mtip1;
   logic [31:0] rd0, rd1;
   logic [63:0] mt0, mt1;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   mtimer_clint #(.PRESCALE(1), .BASE_ADDR(BASE)) u_dut1 (
      .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(rdy0),
      .bus_rdata(rd0), .real_mtime(mt0), .mtip(mtip0));

   mtimer_clint #(.PRESCALE(4), .BASE_ADDR(BASE)) u_dut4 (
      .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(rdy1),
      .bus_rdata(rd1), .real_mtime(mt1), .mtip(mtip1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [63:0] m_time   [2];
   logic [63:0] m_cmp    [2];
   logic [31:0] m_shadow [2];
   logic [31:0] m_rdata  [2];
   logic        m_en     [2];
   logic        m_busy   [2];
   logic        m_ready  [2];
   logic        m_mtip   [2];
   int          m_phase  [2];

   function automatic int ps_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   function automatic int reg_index(input logic [31:0] a);
      logic [31:0] d;
      d = (a & 32'hFFFF_FFFC) - BASE;
      if (d <= 32'h10) return int'(d >> 2);
      return -1;
   endfunction

   task automatic model_reset(input int k);
      m_time[k] = 64'h0; m_cmp[k] = '1; m_shadow[k] = 32'h0; m_rdata[k] = 32'h0;
      m_en[k] = 1'b1; m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_mtip[k] = 1'b0; m_phase[k] = 0;
   endtask

   task automatic model_step(input int k);
      logic [63:0] t;
      logic [31:0] rv;
      logic        acc;
      int          idx;
      acc = !m_busy[k] && bus_valid;
      idx = reg_index(bus_addr);
      m_mtip[k]  = (m_time[k] >= m_cmp[k]);
      m_ready[k] = acc;
      rv = 32'h0;
      if (acc && !bus_we) begin
         case (idx)
            0: rv = m_time[k][31:0];
            1: rv = m_shadow[k];
            2: rv = m_cmp[k][31:0];
            3: rv = m_cmp[k][63:32];
            4: rv = {31'h0, m_en[k]};
            default: rv = 32'h0;
         endcase
         if (idx == 0) m_shadow[k] = m_time[k][63:32];
      end
      m_rdata[k] = rv;
      t = m_time[k];
      if (m_en[k]) begin
         if (m_phase[k] == ps_of(k) - 1) t = t + 64'h1;
         m_phase[k] = (m_phase[k] + 1) % ps_of(k);
      end
      if (acc && bus_we) begin
         case (idx)
            0: t = {m_time[k][63:32], bus_wdata};
            1: t = {bus_wdata, m_time[k][31:0]};
            2: m_cmp[k][31:0] = bus_wdata;
            3: m_cmp[k][63:32] = bus_wdata;
            4: m_en[k] = bus_wdata[0];
            default: ;
         endcase
      end
      m_time[k] = t;
      m_busy[k] = acc;
   endtask

   always @(posedge clk or negedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst) model_reset(k);
         else      model_step(k);
      end
   end

   always @(negedge clk) begin
      check("mtime_ps1", mt0, m_time[0]);
      check("mtip_ps1", mtip0, m_mtip[0]);
      check("ready_ps1", rdy0, m_ready[0]);
      check("rdata_ps1", rd0, m_rdata[0]);
      check("mtime_ps4", mt1, m_time[1]);
      check("mtip_ps4", mtip1, m_mtip[1]);
      check("ready_ps4", rdy1, m_ready[1]);
      check("rdata_ps4", rd1, m_rdata[1]);
   end

   // ---------------- bus driver ----------------
   logic [63:0] resp_mt0, resp_mt1;
   logic        resp_mtip0;

   // Must be entered right after a negedge with the slave idle; returns after a negedge.
   task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] r0, output logic [31:0] r1);
      bus_valid = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      check("xfer_ready_ps1", rdy0, 1'b1);
      check("xfer_ready_ps4", rdy1, 1'b1);
      r0 = rd0; r1 = rd1;
      resp_mt0 = mt0; resp_mt1 = mt1; resp_mtip0 = mtip0;
      @(posedge clk);
      @(negedge clk);
      bus_valid = 1'b0; bus_we = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  off;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vt [14];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r0, r1, cmpv, wd, addr;
      logic [63:0] snap0, snap1;
      int          n, offr;
      logic        wer;

      vt[0]  = '{1'b1, 8'h08, 32'h1234_5678, 32'h0};
      vt[1]  = '{1'b0, 8'h08, 32'h0,         32'h1234_5678};
      vt[2]  = '{1'b1, 8'h0C, 32'hDEAD_BEEF, 32'h0};
      vt[3]  = '{1'b0, 8'h0F, 32'h0,         32'hDEAD_BEEF};
      vt[4]  = '{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0};
      vt[5]  = '{1'b0, 8'h10, 32'h0,         32'h0000_0001};
      vt[6]  = '{1'b0, 8'h14, 32'h0,         32'h0};
      vt[7]  = '{1'b1, 8'h18, 32'hAAAA_5555, 32'h0};
      vt[8]  = '{1'b0, 8'h18, 32'h0,         32'h0};
      vt[9]  = '{1'b0, 8'h1D, 32'h0,         32'h0};
      vt[10] = '{1'b1, 8'h12, 32'h0000_0002, 32'h0};
      vt[11] = '{1'b0, 8'h10, 32'h0,         32'h0};
      vt[12] = '{1'b1, 8'h10, 32'h0000_0001, 32'h0};
      vt[13] = '{1'b0, 8'h11, 32'h0,         32'h0000_0001};

      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // T1: free run after reset
      repeat (10) @(negedge clk);
      check("t1_mtime", mt0, 64'd10);
      check("t1_mtip", mtip0, 1'b0);
      check("t1_ready", rdy0, 1'b0);
      check("t1_rdata", rd0, 32'h0);
      check("t1_mtime_ps4", mt1, 64'd2);
      repeat (6) @(negedge clk);
      check("t2_mtime_ps4", mt1, 64'd4);

      // T2: EN=0 holds, EN=1 resumes
      bus_xfer(1'b1, BASE + 32'h10, 32'h0, r0, r1);
      snap0 = m_time[0]; snap1 = m_time[1];
      repeat (8) @(negedge clk);
      check("t2_hold_ps1", mt0, snap0);
      check("t2_hold_ps4", mt1, snap1);
      bus_xfer(1'b1, BASE + 32'h10, 32'h1, r0, r1);
      repeat (8) @(negedge clk);

      // register access table
      for (int i = 0; i < 14; i++) begin
         bus_xfer(vt[i].we, BASE + {24'h0, vt[i].off}, vt[i].wdata, r0, r1);
         if (!vt[i].we) begin
            check("table_rd_ps1", r0, vt[i].exp);
            check("table_rd_ps4", r1, vt[i].exp);
         end
      end

      // T3: tear-free LO/HI read across a carry
      bus_xfer(1'b1, BASE + 32'h4, 32'h0, r0, r1);
      bus_xfer(1'b1, BASE + 32'h0, 32'hFFFF_FFFE, r0, r1);
      bus_xfer(1'b0, BASE + 32'h0, 32'h0, r0, r1);
      check("t3_lo", r0, 32'hFFFF_FFFF);
      bus_xfer(1'b0, BASE + 32'h4, 32'h0, r0, r1);
      check("t3_hi_shadow", r0, 32'h0);
      bus_xfer(1'b0, BASE + 32'h0, 32'h0, r0, r1);
      bus_xfer(1'b0, BASE + 32'h4, 32'h0, r0, r1);
      check("t3_hi_fresh", r0, 32'h1);

      // T4: mtip rise and fall timing
      bus_xfer(1'b1, BASE + 32'h4, 32'h0, r0, r1);
      bus_xfer(1'b1, BASE + 32'h0, 32'h0, r0, r1);
      bus_xfer(1'b1, BASE + 32'hC, 32'h0, r0, r1);
      cmpv = m_time[0][31:0] + 32'd20;
      bus_xfer(1'b1, BASE + 32'h8, cmpv, r0, r1);
      n = 0;
      while ((mt0 != {32'h0, cmpv}) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      check("t4_reach_in_time", (n < 100), 1'b1);
      check("t4_mtip_at_equal", mtip0, 1'b0);
      @(negedge clk);
      check("t4_mtip_rise", mtip0, 1'b1);
      bus_xfer(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, r0, r1);
      check("t4_mtip_resp", resp_mtip0, 1'b1);
      check("t4_mtip_fall", mtip0, 1'b0);

      // T5: write to MTIME_LO on a wrap edge
      n = 0;
      while ((m_phase[1] != 3) && (n < 8)) begin
         @(negedge clk);
         n++;
      end
      bus_xfer(1'b1, BASE + 32'h0, 32'h100, r0, r1);
      check("t5_lo_ps1", resp_mt0[31:0], 32'h100);
      check("t5_lo_ps4", resp_mt1[31:0], 32'h100);
      check("t5_next_ps1", mt0[31:0], 32'h101);
      check("t5_hold_ps4", mt1[31:0], 32'h100);
      repeat (2) @(negedge clk);
      check("t5_hold2_ps4", mt1[31:0], 32'h100);
      @(negedge clk);
      check("t5_next_ps4", mt1[31:0], 32'h101);
      bus_xfer(1'b0, BASE + 32'h14, 32'h0, r0, r1);
      check("t5_unmapped_ps1", r0, 32'h0);
      check("t5_unmapped_ps4", r1, 32'h0);

      // random traffic against the model
      for (int i = 0; i < 200; i++) begin
         n = $urandom_range(0, 2);
         repeat (n) @(negedge clk);
         offr = $urandom_range(0, 7);
         wer  = 1'($urandom_range(0, 1));
         case (offr)
            0: wd = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            1: wd = 32'($urandom_range(0, 3));
            2: wd = m_time[0][31:0] + 32'($urandom_range(0, 40));
            3: wd = m_time[0][63:32];
            4: begin wd = $urandom; wd[0] = ($urandom_range(0, 3) != 0); end
            default: wd = $urandom;
         endcase
         addr = BASE + 32'(offr * 4) + 32'($urandom_range(0, 3));
         bus_xfer(wer, addr, wd, r0, r1);
      end

      // T6: reset during the response of a MTIMECMP_LO write
      bus_valid = 1'b1; bus_we = 1'b1; bus_addr = BASE + 32'h8; bus_wdata = 32'h55;
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("t6_ready_drop_ps1", rdy0, 1'b0);
      check("t6_ready_drop_ps4", rdy1, 1'b0);
      check("t6_mtime_reset", mt0, 64'h0);
      check("t6_mtip_reset", mtip0, 1'b0);
      @(negedge clk);
      bus_valid = 1'b0; bus_we = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("t6_mtime_zero", mt0, 64'h0);
      bus_xfer(1'b0, BASE + 32'h8, 32'h0, r0, r1);
      check("t6_cmp_lo", r0, 32'hFFFF_FFFF);
      bus_xfer(1'b0, BASE + 32'hC, 32'h0, r0, r1);
      check("t6_cmp_hi", r0, 32'hFFFF_FFFF);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
